serial_subtractor_8bit: RTL and testbench

- Bit-serial A − B subtractor; the inverse-operation companion to the combinational half/full adder blocks.
- Processes one bit per clock, LSB first, through a single 1-bit full subtractor cell with a registered borrow.
- Trades latency for area in the FPGA course datapath.
- Start/done handshake; results are held until the next operation.

---
 rtl/sub_pkg.sv | 15 +
 rtl/serial_subtractor_8bit_if.sv | 33 +++
 rtl/full_subtractor_1bit.sv | 13 +
 rtl/serial_subtractor_8bit.sv | 137 +++++++++++++
 tb/tb_serial_subtractor_8bit.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sub_pkg.sv
// Shared constants for the bit-serial subtractor: default width, FSM encoding,
// and the bit-counter width helper.
package sub_pkg;

    localparam int unsigned SUB_WIDTH = 8;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // Counter must reach WIDTH itself, hence the extra bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_8bit_if.sv
// Start/done handshake and operand/result bus of the serial subtractor.
// Ovf exists only when SUB_OVERFLOW_EN is defined.
interface serial_subtractor_8bit_if #(
    parameter int unsigned WIDTH = sub_pkg::SUB_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
`ifdef SUB_OVERFLOW_EN
    logic             Ovf;
`endif

    modport master (
        output start, A, B,
`ifdef SUB_OVERFLOW_EN
        input  Ovf,
`endif
        input  busy, done, Diff, Bout
    );

    modport slave (
        input  start, A, B,
`ifdef SUB_OVERFLOW_EN
        output Ovf,
`endif
        output busy, done, Diff, Bout
    );

endinterface

// File: rtl/full_subtractor_1bit.sv
// Combinational 1-bit full subtractor cell: Diff = A - B - Bin, Bout = borrow out.
module full_subtractor_1bit (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic Diff,
    output logic Bout
);

    assign Diff = A ^ B ^ Bin;
    assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial A - B subtractor, LSB first, one bit per clock, registered borrow.
// Define SUB_OVERFLOW_EN to add the signed-overflow output Ovf.
module serial_subtractor_8bit
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH = SUB_WIDTH
) (
    input logic                    clk,
    input logic                    rst_n,
    serial_subtractor_8bit_if.slave bus
);

    localparam int unsigned   CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [0:0]       state_q, state_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic [WIDTH-1:0] a_q, a_n;
    logic [WIDTH-1:0] b_q, b_n;
    logic [WIDTH-1:0] res_q, res_n;
    logic             borrow_q, borrow_n;
    logic [WIDTH-1:0] diff_q, diff_n;
    logic             bout_q, bout_n;
    logic             done_q, done_n;
`ifdef SUB_OVERFLOW_EN
    logic             ma_q, ma_n;
    logic             mb_q, mb_n;
    logic             ovf_q, ovf_n;
`endif

    logic cell_d;
    logic cell_bo;

    full_subtractor_1bit u_cell (
        .A    (a_q[0]),
        .B    (b_q[0]),
        .Bin  (borrow_q),
        .Diff (cell_d),
        .Bout (cell_bo)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            ma_q     <= 1'b0;
            mb_q     <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            a_q      <= a_n;
            b_q      <= b_n;
            res_q    <= res_n;
            borrow_q <= borrow_n;
            diff_q   <= diff_n;
            bout_q   <= bout_n;
            done_q   <= done_n;
`ifdef SUB_OVERFLOW_EN
            ma_q     <= ma_n;
            mb_q     <= mb_n;
            ovf_q    <= ovf_n;
`endif
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        a_n      = a_q;
        b_n      = b_q;
        res_n    = res_q;
        borrow_n = borrow_q;
        diff_n   = diff_q;
        bout_n   = bout_q;
        done_n   = 1'b0;
`ifdef SUB_OVERFLOW_EN
        ma_n     = ma_q;
        mb_n     = mb_q;
        ovf_n    = ovf_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_n  = RUN;
                    a_n      = bus.A;
                    b_n      = bus.B;
                    cnt_n    = '0;
                    borrow_n = 1'b0;
`ifdef SUB_OVERFLOW_EN
                    ma_n     = bus.A[WIDTH-1];
                    mb_n     = bus.B[WIDTH-1];
`endif
                end
            end
            RUN: begin
                a_n      = a_q >> 1;
                b_n      = b_q >> 1;
                res_n    = {cell_d, res_q[WIDTH-1:1]};
                borrow_n = cell_bo;
                cnt_n    = cnt_q + CW'(1);
                // Last bit: publish the full result and the final borrow together.
                if (cnt_q == LAST) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    diff_n  = {cell_d, res_q[WIDTH-1:1]};
                    bout_n  = cell_bo;
`ifdef SUB_OVERFLOW_EN
                    ovf_n   = (ma_q ^ mb_q) & (ma_q ^ cell_d);
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = done_q;
    assign bus.Diff = diff_q;
    assign bus.Bout = bout_q;
`ifdef SUB_OVERFLOW_EN
    assign bus.Ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Directed and random self-checking bench for serial_subtractor_8bit.
// Ovf checks are compiled in when SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor_8bit;

    localparam int unsigned W = 8;
    localparam int          TIMEOUT = 20;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    serial_subtractor_8bit_if #(.WIDTH(W)) bus ();

    serial_subtractor_8bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic get_ovf();
`ifdef SUB_OVERFLOW_EN
        return bus.Ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Launch one operation and wait for done; reports latency, busy cycles,
    // whether the visible result moved before done, and the final outputs.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int busy_cyc, output logic partial,
                         output logic [W-1:0] diff, output logic bout, output logic ovf);
        logic [W-1:0] d0;
        logic         b0;
        @(negedge clk);
        d0 = bus.Diff;
        b0 = bus.Bout;
        bus.start = 1'b1;
        bus.A = a;
        bus.B = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.A = ~a;
        bus.B = ~b;
        busy_cyc = bus.busy ? 1 : 0;
        partial = 1'b0;
        lat = 0;
        while (lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) break;
            if (bus.busy) busy_cyc++;
            if (bus.Diff !== d0 || bus.Bout !== b0) partial = 1'b1;
        end
        diff = bus.Diff;
        bout = bus.Bout;
        ovf  = get_ovf();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.Diff, bus.Bout, get_ovf()} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: busy=%b done=%b Diff=%h Bout=%b Ovf=%b, need all 0",
                     bus.busy, bus.done, bus.Diff, bus.Bout, get_ovf());
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: busy=%b done=%b, need 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] va[4] = '{8'h05, 8'h03, 8'h00, 8'hA5};
        logic [W-1:0] vb[4] = '{8'h03, 8'h05, 8'hFF, 8'hA5};
        logic [W-1:0] ed[4] = '{8'h02, 8'hFE, 8'h01, 8'h00};
        logic         eb[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic         eo[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
        int lat, bc;
        logic part, bo, ov;
        logic [W-1:0] d;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], lat, bc, part, d, bo, ov);
            n_cmp++;
            if (d !== ed[i] || bo !== eb[i]) begin
                n_bad++;
                $display("FAIL basic_result[%0d]: Diff=%h Bout=%b, need %h %b", i, d, bo, ed[i], eb[i]);
            end
            n_cmp++;
            if (lat != W || bc != W) begin
                n_bad++;
                $display("FAIL basic_timing[%0d]: latency=%0d busy=%0d, need %0d %0d", i, lat, bc, W, W);
            end
            n_cmp++;
            if (part !== 1'b0) begin
                n_bad++;
                $display("FAIL basic_hold[%0d]: Diff/Bout moved before done", i);
            end
`ifdef SUB_OVERFLOW_EN
            n_cmp++;
            if (ov !== eo[i]) begin
                n_bad++;
                $display("FAIL basic_ovf[%0d]: Ovf=%b, need %b", i, ov, eo[i]);
            end
`endif
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.done !== 1'b0 || bus.Diff !== 8'h00) begin
            n_bad++;
            $display("FAIL done_pulse_width: done=%b Diff=%h, need 0 00", bus.done, bus.Diff);
        end
    endtask

    task automatic test_start_held();
        int dones, cyc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A = 8'h3C;
        bus.B = 8'h0F;
        dones = 0;
        cyc = 0;
        @(posedge clk);
        while (cyc < TIMEOUT) begin
            #1;
            bus.A = 8'($urandom);
            bus.B = 8'($urandom);
            @(posedge clk);
            #1;
            cyc++;
            if (bus.done) begin
                dones++;
                bus.start = 1'b0;
                break;
            end
        end
        bus.start = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        n_cmp++;
        if (dones != 1 || cyc != W) begin
            n_bad++;
            $display("FAIL start_held_done: dones=%0d latency=%0d, need 1 %0d", dones, cyc, W);
        end
        n_cmp++;
        if (bus.Diff !== 8'h2D || bus.Bout !== 1'b0 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL start_held_result: Diff=%h Bout=%b busy=%b, need 2d 0 0",
                     bus.Diff, bus.Bout, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc, cyc;
        logic part, bo, ov;
        logic [W-1:0] d;
        do_op(8'h05, 8'h03, lat, bc, part, d, bo, ov);
        bus.start = 1'b1;
        bus.A = 8'h80;
        bus.B = 8'h01;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_accept: busy=%b, need 1", bus.busy);
        end
        cyc = 0;
        while (cyc < TIMEOUT) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.done) break;
        end
        n_cmp++;
        if (cyc != W || bus.Diff !== 8'h7F || bus.Bout !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_result: latency=%0d Diff=%h Bout=%b, need %0d 7f 0",
                     cyc, bus.Diff, bus.Bout, W);
        end
`ifdef SUB_OVERFLOW_EN
        n_cmp++;
        if (ov !== 1'b0 || bus.Ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_ovf: first=%b second=%b, need 0 1", ov, bus.Ovf);
        end
`endif
    endtask

    task automatic test_reset_midop();
        int lat, bc, dones;
        logic part, bo, ov;
        logic [W-1:0] d;
        do_op(8'h03, 8'h05, lat, bc, part, d, bo, ov);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A = 8'h44;
        bus.B = 8'h22;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.Diff, bus.Bout, get_ovf()} !== '0) begin
            n_bad++;
            $display("FAIL midop_reset: busy=%b done=%b Diff=%h Bout=%b, need all 0",
                     bus.busy, bus.done, bus.Diff, bus.Bout);
        end
        dones = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 2) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        n_cmp++;
        if (dones != 0) begin
            n_bad++;
            $display("FAIL midop_no_done: dones=%0d, need 0", dones);
        end
        do_op(8'h10, 8'h01, lat, bc, part, d, bo, ov);
        n_cmp++;
        if (d !== 8'h0F || bo !== 1'b0 || lat != W) begin
            n_bad++;
            $display("FAIL post_reset_op: Diff=%h Bout=%b latency=%0d, need 0f 0 %0d", d, bo, lat, W);
        end
    endtask

    task automatic test_random();
        int lat, bc, sa, sb, sd, errs;
        logic part, bo, ov, eb, eo;
        logic [W-1:0] a, b, d, ed;
        errs = 0;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            do_op(a, b, lat, bc, part, d, bo, ov);
            ed = 8'(int'(a) - int'(b) + 256);
            eb = (int'(a) < int'(b));
            sa = (int'(a) > 127) ? int'(a) - 256 : int'(a);
            sb = (int'(b) > 127) ? int'(b) - 256 : int'(b);
            sd = sa - sb;
            eo = (sd > 127) || (sd < -128);
`ifndef SUB_OVERFLOW_EN
            eo = 1'b0;
`endif
            n_cmp++;
            if (d !== ed || bo !== eb || ov !== eo || lat != W) begin
                n_bad++;
                errs++;
                if (errs <= 5)
                    $display("FAIL random[%0d] %h-%h: Diff=%h Bout=%b Ovf=%b lat=%0d, need %h %b %b %0d",
                             i, a, b, d, bo, ov, lat, ed, eb, eo, W);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_basic();
        test_start_held();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
